// File: rtl/boot_loader_if.sv
// rtl/boot_loader_if.sv - byte stream in, ROM write port and status out for the boot loader
interface boot_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        in_data_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic              reload_i;
    logic              rom_we_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [31:0]       rom_data_o;
    logic              cpu_hold_o;
    logic              done_o;
    logic              err_o;
    logic [15:0]       words_o;

    modport master (
        output in_data_i, in_valid_i, reload_i,
        input  in_ready_o, rom_we_o, rom_addr_o, rom_data_o,
        input  cpu_hold_o, done_o, err_o, words_o
    );

    modport slave (
        input  in_data_i, in_valid_i, reload_i,
        output in_ready_o, rom_we_o, rom_addr_o, rom_data_o,
        output cpu_hold_o, done_o, err_o, words_o
    );
endinterface

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - streams a length-prefixed, checksummed image into instruction ROM
module boot_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic           clk_i,
    input  logic           rst_i,
    boot_loader_if.slave   bus
);
    typedef enum logic [2:0] {
        S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [16:0]       MAX_WORDS = 17'd1 << ADDR_W;

    state_t            state, state_nx;
    logic [7:0]        len_lo;
    logic [15:0]       len;
    logic [15:0]       words;
    logic [1:0]        byte_cnt;
    logic [23:0]       word_sr;
    logic [7:0]        sum;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_data;

    logic              in_ready;
    logic              accept;
    logic              last_word;
    logic [15:0]       len_full;

    assign in_ready  = (state != S_DONE) && (state != S_ERR);
    assign accept    = bus.in_valid_i && in_ready;
    assign len_full  = {bus.in_data_i, len_lo};
    assign last_word = ((words + 16'd1) == len);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_LEN0;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (bus.reload_i) begin
            state_nx = S_LEN0;
        end else if (accept) begin
            case (state)
                S_LEN0: state_nx = S_LEN1;
                S_LEN1: begin
                    if ({1'b0, len_full} > MAX_WORDS) begin
                        state_nx = S_ERR;
                    end else if (len_full == 16'd0) begin
                        state_nx = S_CSUM;
                    end else begin
                        state_nx = S_DATA;
                    end
                end
                S_DATA: begin
                    if (byte_cnt == 2'd3 && last_word) begin
                        state_nx = S_CSUM;
                    end
                end
                S_CSUM: state_nx = (bus.in_data_i == sum) ? S_DONE : S_ERR;
                default: state_nx = state;
            endcase
        end
    end

    // Reload outranks a byte accepted in the same cycle, so it is tested first.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            len_lo   <= '0;
            len      <= '0;
            words    <= '0;
            byte_cnt <= '0;
            word_sr  <= '0;
            sum      <= '0;
            rom_we   <= 1'b0;
            rom_addr <= '0;
            rom_data <= '0;
        end else begin
            rom_we <= 1'b0;
            if (bus.reload_i) begin
                len_lo   <= '0;
                len      <= '0;
                words    <= '0;
                byte_cnt <= '0;
                sum      <= '0;
            end else if (accept) begin
                case (state)
                    S_LEN0: len_lo <= bus.in_data_i;
                    S_LEN1: len    <= len_full;
                    S_DATA: begin
                        sum      <= sum + bus.in_data_i;
                        byte_cnt <= byte_cnt + 2'd1;
                        word_sr  <= {bus.in_data_i, word_sr[23:8]};
                        if (byte_cnt == 2'd3) begin
                            rom_we   <= 1'b1;
                            rom_addr <= BASE + ADDR_W'(words);
                            rom_data <= {bus.in_data_i, word_sr};
                            words    <= words + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready_o = in_ready;
    assign bus.rom_we_o   = rom_we;
    assign bus.rom_addr_o = rom_addr;
    assign bus.rom_data_o = rom_data;
    assign bus.cpu_hold_o = (state != S_DONE);
    assign bus.done_o     = (state == S_DONE);
    assign bus.err_o      = (state == S_ERR);
    assign bus.words_o    = words;
endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - directed checks of the boot loader against hand-computed images
module tb_boot_loader;
    localparam int ADDR_W = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   we_count = 0;
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    logic [7:0]  q [$];

    boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    boot_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.rom_we_o === 1'b1) begin
            mem[bus.rom_addr_o] = bus.rom_data_o;
            we_count++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        we_count = 0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'hDEAD_BEEF;
    endtask

    // Called at a negedge; each byte is presented for one rising edge.
    task automatic send(input bit throttle);
        for (int i = 0; i < q.size(); i++) begin
            bus.in_data_i  = q[i];
            bus.in_valid_i = 1'b1;
            @(negedge clk);
            if (throttle) begin
                bus.in_valid_i = 1'b0;
                bus.in_data_i  = 8'hFF;
                @(negedge clk);
            end
        end
        bus.in_valid_i = 1'b0;
    endtask

    task automatic reload_pulse();
        bus.reload_i = 1'b1;
        @(negedge clk);
        bus.reload_i = 1'b0;
    endtask

    task automatic check_normal(input string tag);
        check({tag, "_rom0"}, mem[0], 32'h0000_0013);
        check({tag, "_rom1"}, mem[1], 32'h0010_0093);
        check({tag, "_we"}, 32'(we_count), 32'd2);
        check({tag, "_words"}, 32'(bus.words_o), 32'd2);
        check({tag, "_done"}, 32'(bus.done_o), 32'd1);
        check({tag, "_hold"}, 32'(bus.cpu_hold_o), 32'd0);
        check({tag, "_err"}, 32'(bus.err_o), 32'd0);
    endtask

    initial begin
        bus.in_data_i  = 8'h00;
        bus.in_valid_i = 1'b0;
        bus.reload_i   = 1'b0;
        clear_model();
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus.in_ready_o), 32'd1);
        check("rst_we", 32'(bus.rom_we_o), 32'd0);
        check("rst_addr", 32'(bus.rom_addr_o), 32'd0);
        check("rst_data", bus.rom_data_o, 32'd0);
        check("rst_hold", 32'(bus.cpu_hold_o), 32'd1);
        check("rst_done", 32'(bus.done_o), 32'd0);
        check("rst_err", 32'(bus.err_o), 32'd0);
        check("rst_words", 32'(bus.words_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Normal load, with write-latency and done-timing probes along the way
        q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        send(1'b0);
        check("lat_we", 32'(bus.rom_we_o), 32'd1);
        check("lat_addr", 32'(bus.rom_addr_o), 32'd0);
        check("lat_data", bus.rom_data_o, 32'h0000_0013);
        check("lat_words", 32'(bus.words_o), 32'd1);
        q = '{8'h93};
        send(1'b0);
        check("lat_we_pulse", 32'(bus.rom_we_o), 32'd0);
        q = '{8'h00, 8'h10, 8'h00};
        send(1'b0);
        check("lat_we2_addr", 32'(bus.rom_addr_o), 32'd1);
        check("pre_csum_hold", 32'(bus.cpu_hold_o), 32'd1);
        q = '{8'hB6};
        send(1'b0);
        check_normal("normal");
        check("normal_ready", 32'(bus.in_ready_o), 32'd0);

        // Bad checksum
        reload_pulse();
        check("reload_hold", 32'(bus.cpu_hold_o), 32'd1);
        check("reload_words", 32'(bus.words_o), 32'd0);
        clear_model();
        q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB7};
        send(1'b0);
        check("bad_rom0", mem[0], 32'h0000_0013);
        check("bad_rom1", mem[1], 32'h0010_0093);
        check("bad_we", 32'(we_count), 32'd2);
        check("bad_err", 32'(bus.err_o), 32'd1);
        check("bad_hold", 32'(bus.cpu_hold_o), 32'd1);
        check("bad_ready", 32'(bus.in_ready_o), 32'd0);

        // Length overflow: 0x0401 words
        reload_pulse();
        clear_model();
        q = '{8'h01, 8'h04};
        send(1'b0);
        check("ovf_err", 32'(bus.err_o), 32'd1);
        check("ovf_ready", 32'(bus.in_ready_o), 32'd0);
        check("ovf_we", 32'(we_count), 32'd0);

        // Exactly full ROM is a legal length
        reload_pulse();
        q = '{8'h00, 8'h04};
        send(1'b0);
        check("max_err", 32'(bus.err_o), 32'd0);
        check("max_ready", 32'(bus.in_ready_o), 32'd1);

        // Empty image
        reload_pulse();
        clear_model();
        q = '{8'h00, 8'h00, 8'h00};
        send(1'b0);
        check("empty_done", 32'(bus.done_o), 32'd1);
        check("empty_we", 32'(we_count), 32'd0);
        check("empty_words", 32'(bus.words_o), 32'd0);

        // Throttled input
        reload_pulse();
        clear_model();
        q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
        send(1'b1);
        check_normal("thr");

        // Abort mid-word by reload; the byte sharing the reload cycle is dropped
        reload_pulse();
        clear_model();
        q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00};
        send(1'b0);
        bus.in_data_i  = 8'h00;
        bus.in_valid_i = 1'b1;
        bus.reload_i   = 1'b1;
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        bus.reload_i   = 1'b0;
        @(negedge clk);
        check("abort_we", 32'(we_count), 32'd0);
        check("abort_words", 32'(bus.words_o), 32'd0);
        check("abort_ready", 32'(bus.in_ready_o), 32'd1);
        q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
        send(1'b0);
        check_normal("abort");

        // Abort mid-word by asynchronous reset
        reload_pulse();
        clear_model();
        q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00};
        send(1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("arst_hold", 32'(bus.cpu_hold_o), 32'd1);
        check("arst_words", 32'(bus.words_o), 32'd0);
        check("arst_ready", 32'(bus.in_ready_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_we", 32'(we_count), 32'd0);
        q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
        send(1'b0);
        check_normal("arst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
